calc_sequencer: RTL
===================

// Module: calc_sequencer
// PURPOSE
//  Sequences the 4-bit register/ALU calculator from a small on-chip program memory.
//  A host loads up to DEPTH instructions while the block is idle, then pulses start.
//  Each instruction drives one calculator op per clk; after the last op the result register is read back.
//  The calculator's register file writes on every falling clk edge.
//  The block therefore drives a value-preserving NOP whenever it is not executing.
// PARAMETERS
//  DEPTH  8  program memory entries; power of two, >=2
//  AW     3  program address width = log2(DEPTH)
// PORTS
//  clk             in   1    clock; all state updates on posedge; calculator samples on negedge
//  reset           in   1    synchronous, active-high
//  start           in   1    run request; sampled only in IDLE
//  last_pc         in   AW   index of last instruction to run; captured with start
//  prog_we         in   1    program write strobe; honoured only in IDLE
//  prog_addr       in   AW   program write address
//  prog_data       in   11   instruction {control[2:0], we_addr[1:0], rd_addr[1:0], imm[3:0]}
//  calc_rd_data    in   4    calculator rd_data
//  calc_rd_addr    out  2    calculator rd_addr
//  calc_immediate  out  4    calculator immediate
//  calc_we_addr    out  2    calculator we_addr
//  calc_control    out  3    calculator control: [2]=invert b + carry-in; [1:0] 00 and, 01 or, 10 add, 11 slt
//  busy            out  1    high in RUN and DRAIN
//  done            out  1    one-cycle pulse when result is valid
//  result          out  4    value of the last instruction's destination register; held until next done
//  pc              out  AW   current instruction index
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; busy=0, done=0, result=0, pc=0.
//   - Program memory is NOT cleared. The calculator registers are not touched.
//  NOP (IDLE and reset): rd_addr=0, we_addr=0, immediate=0, control=3'b001 (r0 <= r0|0).
//  calc_* outputs:
//   - Decoded from registered state/pc plus an asynchronous memory read.
//   - Settled within half a cycle, before the negedge.
//  IDLE:
//   - prog_we=1 writes prog_data to mem[prog_addr] at the posedge.
//   - start=1 captures last_pc into lp, sets pc=0, and moves to RUN. busy=1 from the next cycle.
//   - If start and prog_we are asserted in the same cycle, both take effect.
//   - The write is visible to the run if it targets any index.
//  RUN:
//   - calc_* = fields of mem[pc].
//   - If pc==lp: capture dst=mem[pc].we_addr and go to DRAIN. Otherwise pc<=pc+1.
//  DRAIN:
//   - Drives NOP on dst: rd_addr=we_addr=dst, imm=0, control=001. This rewrites the same value.
//   - At the ending posedge: result<=calc_rd_data, done<=1, pc<=0, state<=IDLE.
//  Latency:
//   - start sampled at edge t. Instruction i executes in cycle t+1+i (written at that cycle's negedge).
//   - DRAIN occupies cycle t+lp+2. done=1 in cycle t+lp+3.
//   - Total: start to done = lp+3 cycles.
//  While busy:
//   - start and prog_we are ignored; memory is unchanged; last_pc changes have no effect.
//  Boundaries:
//   - last_pc=0 runs exactly one instruction.
//   - last_pc=DEPTH-1 runs all entries; pc never wraps past lp.
//   - reset in any state returns to IDLE next cycle with NOP outputs and done=0. No pulse for the aborted run.
//   - Instructions already executed stay in the calculator registers.
//  done pulses once per completed run. A start sampled in the done cycle (IDLE) begins a new run.
//  Arithmetic is the calculator's (4-bit wrap, signed slt). The block does not interpret data.
// TESTING
//  1 reset asserted 2 cycles -> busy=0, done=0, result=0, pc=0, calc_*={rd0,we0,imm0,ctl001}.
//  2 load {001,01,00,0101}, {010,01,01,0011}, {110,10,01,0001}; start with last_pc=2 -> busy 4 cycles.
//    done=1 exactly 5 cycles after the start edge, result=7 (r1=5, r1=8, r2=7).
//  3 load {001,01,00,1010}, {011,11,01,0010}; last_pc=1 -> result=1 (-6 < 2 signed).
//    Then rerun with imm 4'b1000 in entry 1 -> result=0.
//  4 during test-2 run: pulse start and prog_we(addr 0, data 0) -> no effect.
//    Rerun gives result=7 and a single done per run.
//  5 reset asserted in 2nd RUN cycle -> IDLE and NOP next cycle; busy=0; no done.
//    A fresh start completes normally.
//  6 last_pc=0 -> done 3 cycles after start.
//    last_pc=7 with 8 loaded "add 1 to r1" ops -> r1 increases by 8 mod 16; pc never exceeds 7.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: runs a short program from on-chip memory through the 4-bit
// register/ALU calculator, one operation per clock. When the last instruction
// has executed, its destination register is read back as the result. The
// calculator's register file writes on every falling edge, so this block drives
// a value-preserving NOP whenever it is not executing an instruction.
`timescale 1ns/1ps

module calc_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] last_pc,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [10:0]   prog_data,
    input  logic [3:0]    calc_rd_data,
    output logic [1:0]    calc_rd_addr,
    output logic [3:0]    calc_immediate,
    output logic [1:0]    calc_we_addr,
    output logic [2:0]    calc_control,
    output logic          busy,
    output logic          done,
    output logic [3:0]    result,
    output logic [AW-1:0] pc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // r0 <= r0 | 0 : rewrites r0 with its own value
    localparam logic [2:0] CTL_OR = 3'b001;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] lp_q, lp_d;
    logic [1:0]    dst_q, dst_d;
    logic [3:0]    result_q, result_d;
    logic          done_q, done_d;

    logic [10:0]   mem [DEPTH];
    logic [10:0]   instr;

    // Instruction word: {control[2:0], we_addr[1:0], rd_addr[1:0], imm[3:0]}
    assign instr = mem[pc_q];

    // Program memory: host writes are accepted only while idle
    // NOTE: the memory has no reset branch on purpose; the program survives
    // reset, and a reset-free array maps onto plain RAM instead of flops.
    always_ff @(posedge clk) begin
        if (!reset && prog_we && state_q == S_IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Control state register with synchronous reset
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            lp_q     <= '0;
            dst_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            lp_q     <= lp_d;
            dst_q    <= dst_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: idle -> run program 0..lp -> one drain cycle to read back
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        lp_d     = lp_q;
        dst_d    = dst_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lp_d    = last_pc;
                    pc_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (pc_q == lp_q) begin
                    dst_d   = instr[7:6];
                    state_d = S_DRAIN;
                end else begin
                    pc_d = pc_q + AW'(1);
                end
            end
            S_DRAIN: begin
                result_d = calc_rd_data;
                done_d   = 1'b1;
                pc_d     = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Calculator drive: NOP when idle, instruction fields when running,
    // and a same-value rewrite of the destination while draining
    always_comb begin
        calc_rd_addr   = 2'd0;
        calc_we_addr   = 2'd0;
        calc_immediate = 4'd0;
        calc_control   = CTL_OR;
        case (state_q)
            S_RUN: begin
                calc_control   = instr[10:8];
                calc_we_addr   = instr[7:6];
                calc_rd_addr   = instr[5:4];
                calc_immediate = instr[3:0];
            end
            S_DRAIN: begin
                calc_rd_addr = dst_q;
                calc_we_addr = dst_q;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign pc     = pc_q;

endmodule
